// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding one AXI-Stream DMA FIFO input.
// Optional header beat per packet when AXIS_ARB_HDR_EN is defined.
module axis_pkt_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DW      = 64,
    parameter int ID_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [31:0]           packet_size,
    input  logic [NUM_SRC-1:0]    src_valid,
    input  logic [NUM_SRC*DW-1:0] src_data,
    output logic [NUM_SRC-1:0]    src_ready,
    output logic [DW-1:0]         m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [DW/8-1:0]       m_tkeep,
    output logic [ID_W-1:0]       grant_id,
    output logic                  busy,
    output logic [31:0]           pkt_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        XFER = 2'd2
    } state_t;

`ifdef AXIS_ARB_HDR_EN
    localparam state_t FIRST = HDR;
`else
    localparam state_t FIRST = XFER;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] sel;
    logic            sel_ok;
    logic [31:0]     pkt_len;
    logic [31:0]     beat_cnt;
    logic [DW-1:0]   gdata;
    logic            gvalid;
    logic            grant;
    logic            beat;

`ifdef AXIS_ARB_HDR_EN
    logic [31:0]     size_lat;
    logic [63:0]     hdr;

    assign hdr = {8'(grant_id), 8'h00, pkt_count[15:0], size_lat};
`endif

    assign m_tkeep = '1;
    assign busy    = (state != IDLE);
    assign grant   = (state == IDLE) && (state_nxt != IDLE);
    assign beat    = (state == XFER) && m_tvalid && m_tready;

    // Scan from farthest to nearest so the nearest requester after
    // last_grant is the one left standing.
    always_comb begin
        int idx;
        sel    = '0;
        sel_ok = 1'b0;
        idx    = 0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (src_valid[idx]) begin
                sel    = idx[ID_W-1:0];
                sel_ok = 1'b1;
            end
        end
    end

    always_comb begin
        gdata  = '0;
        gvalid = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id == ID_W'(i)) begin
                gdata  = src_data[i*DW +: DW];
                gvalid = src_valid[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        m_tdata   = '0;
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        src_ready = '0;
        unique case (state)
            IDLE: begin
                if (enable && sel_ok) begin
                    state_nxt = FIRST;
                end
            end
`ifdef AXIS_ARB_HDR_EN
            HDR: begin
                m_tdata  = DW'(hdr);
                m_tvalid = 1'b1;
                if (m_tready) begin
                    state_nxt = XFER;
                end
            end
`endif
            XFER: begin
                m_tdata  = gdata;
                m_tvalid = gvalid;
                m_tlast  = (beat_cnt == pkt_len - 32'd1);
                for (int i = 0; i < NUM_SRC; i++) begin
                    src_ready[i] = (grant_id == ID_W'(i)) && m_tready;
                end
                if (gvalid && m_tready && m_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_SRC - 1);
            pkt_len    <= 32'd1;
            beat_cnt   <= '0;
            pkt_count  <= '0;
`ifdef AXIS_ARB_HDR_EN
            size_lat   <= '0;
`endif
        end else begin
            if (grant) begin
                grant_id <= sel;
                pkt_len  <= (packet_size == 32'd0) ? 32'd1 : packet_size;
                beat_cnt <= '0;
`ifdef AXIS_ARB_HDR_EN
                size_lat <= packet_size;
`endif
            end
            if (beat) begin
                if (m_tlast) begin
                    beat_cnt   <= '0;
                    pkt_count  <= pkt_count + 32'd1;
                    last_grant <= grant_id;
                end else begin
                    beat_cnt <= beat_cnt + 32'd1;
                end
            end
        end
    end

endmodule
